// File: rtl/main_data_memory_pkg.sv
// main_mem_pkg: definitions shared by the main-memory responder and the data
// cache's MAIN_MEM_* interface.
//   - mem_state_e : responder FSM states (idle / busy / done)
//   - mem_op_e    : latched operation encoding (OP_READ, OP_WRITE)
//   - DEFAULT_LATENCY, BLOCK_BITS, MEM_ADDR_BITS : interface sizing
package main_mem_pkg;

  localparam int unsigned DEFAULT_LATENCY = 4;
  localparam int unsigned BLOCK_BITS      = 128;
  localparam int unsigned MEM_ADDR_BITS   = 28;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mem_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

  // A request is legal only when exactly one of read/write is raised.
  function automatic logic single_req(input logic read, input logic write);
    return read ^ write;
  endfunction

endpackage

// File: rtl/main_mem_array.sv
// main_mem_array: single-port synchronous block RAM, DATA_WIDTH x 2**INDEX_WIDTH.
//   clock    : write and read both act on the rising edge
//   write_en : store wdata at index
//   read_en  : load mem[index] into rdata (one-cycle registered read)
//   index    : block index
//   wdata    : block to store
//   rdata    : registered read block, holds between reads
// No reset: contents and rdata are left to their power-up state.
module main_mem_array #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned INDEX_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   write_en,
  input  logic                   read_en,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0]  wdata,
  output logic [DATA_WIDTH-1:0]  rdata
);

  localparam int unsigned Depth = 2 ** INDEX_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[index] <= wdata;
    end
    if (read_en) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/main_data_memory.sv
// main_data_memory: main-memory responder for the data cache. Services 128-bit
// block reads and write-backs after a programmable access latency.
//   clock     : system clock
//   reset     : synchronous, active-high
//   read      : block read request (level, held until busywait drops)
//   write     : block write request (level, held until busywait drops)
//   address   : block address; only the low INDEX_WIDTH bits are decoded
//   writedata : block to write
//   readdata  : block from the last completed read, zero after reset
//   busywait  : high while a request is pending or in service
module main_data_memory
  import main_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = MEM_ADDR_BITS,
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned DATA_WIDTH  = BLOCK_BITS,
  parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  busywait
);

  localparam logic [7:0] CntInit = 8'(LATENCY - 1);

  mem_state_e             state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  mem_op_e                op_q, op_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  // Set by the first completed read; gates the RAM's unreset output register
  // so readdata is zero out of reset.
  logic                   have_rd_q, have_rd_d;

  logic                  ram_we, ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Upper block-address bits are deliberately ignored (addresses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[ADDR_WIDTH-1:INDEX_WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    have_rd_d = have_rd_q;
    busywait  = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Combinational so the initiator never sees a false ready on the
        // request cycle; read and write together is ignored.
        busywait = single_req(read, write);
        if (single_req(read, write)) begin
          op_d    = write ? OP_WRITE : OP_READ;
          idx_d   = address[INDEX_WIDTH-1:0];
          wdata_d = writedata;
          cnt_d   = CntInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        busywait = 1'b1;
        if (!(read || write)) begin
          // Request withdrawn: abort without touching the array or readdata.
          state_d = StIdle;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          if (op_q == OP_READ) begin
            ram_re    = 1'b1;
            have_rd_d = 1'b1;
          end else begin
            ram_we = 1'b1;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      op_q      <= OP_READ;
      idx_q     <= '0;
      wdata_q   <= '0;
      have_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      have_rd_q <= have_rd_d;
    end
  end

  main_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_array (
    .clock   (clock),
    // Reset drops an access that would otherwise land on the same edge.
    .write_en(ram_we && !reset),
    .read_en (ram_re && !reset),
    .index   (idx_q),
    .wdata   (wdata_q),
    .rdata   (ram_rdata)
  );

  assign readdata = have_rd_q ? ram_rdata : '0;

endmodule
